// File: rtl/us_arp_tx_if.sv
// Transmit beat stream carrying ARP frames from us_arp_tx to the MAC sink.
// master drives the beat; slave returns tx_ready.
interface us_arp_tx_if;
  logic [63:0] tx_data;
  logic [7:0]  tx_keep;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready;

  modport master (
    output tx_data, tx_keep, tx_valid, tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_data, tx_keep, tx_valid, tx_last,
    output tx_ready
  );
endinterface

// File: rtl/us_arp_tx.sv
// ARP who-has / is-at frame generator on a 64-bit beat stream.
// Define ARP_TX_PAD_EN to zero-pad frames to the 60-byte Ethernet minimum.
module us_arp_tx #(
  parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_02_03,
  parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0101
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        arp_request_req,
  output logic        arp_request_ack,
  input  logic [31:0] dst_ip_addr,
  input  logic        arp_reply_req,
  output logic        arp_reply_ack,
  input  logic [47:0] recv_src_mac_addr,
  input  logic [31:0] recv_src_ip_addr,
  us_arp_tx_if.master tx
);

`ifdef ARP_TX_PAD_EN
  localparam logic [2:0] LAST_BEAT = 3'd7;
  localparam logic [7:0] LAST_KEEP = 8'hF0;
`else
  localparam logic [2:0] LAST_BEAT = 3'd5;
  localparam logic [7:0] LAST_KEEP = 8'hC0;
`endif

  typedef enum logic [1:0] {IDLE, REQ_TX, REP_TX, GAP} state_t;

  state_t      state_q;
  logic [2:0]  beat_cnt_q;
  logic        is_reply_q;
  logic [47:0] snap_mac_q;
  logic [31:0] snap_ip_q;
  logic [63:0] tx_data_q;
  logic [7:0]  tx_keep_q;
  logic        tx_valid_q;
  logic        tx_last_q;
  logic        req_ack_q;
  logic        rep_ack_q;
  logic [2:0]  beat_cnt_d;

  // Whole frame laid out MSB-first in 64 bytes; trailing bytes are the zero pad.
  function automatic logic [63:0] beat_data(input logic [2:0]  idx,
                                            input logic        rep,
                                            input logic [47:0] mac,
                                            input logic [31:0] ip);
    logic [511:0] frm;
    frm = {rep ? mac : 48'hFFFF_FFFF_FFFF, LOCAL_MAC,
           16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
           rep ? 16'h0002 : 16'h0001, LOCAL_MAC, LOCAL_IP,
           rep ? mac : 48'h0, ip, 176'h0};
    return frm[{~idx, 6'b000} +: 64];
  endfunction

  function automatic logic [7:0] beat_keep(input logic [2:0] idx);
    return (idx == LAST_BEAT) ? LAST_KEEP : 8'hFF;
  endfunction

  assign beat_cnt_d = beat_cnt_q + 3'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      beat_cnt_q <= 3'd0;
      is_reply_q <= 1'b0;
      snap_mac_q <= 48'h0;
      snap_ip_q  <= 32'h0;
      tx_data_q  <= 64'h0;
      tx_keep_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      req_ack_q  <= 1'b0;
      rep_ack_q  <= 1'b0;
    end else begin
      req_ack_q <= 1'b0;
      rep_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Reply has priority so a peer waiting on us is answered first.
          if (arp_reply_req) begin
            state_q    <= REP_TX;
            is_reply_q <= 1'b1;
            snap_mac_q <= recv_src_mac_addr;
            snap_ip_q  <= recv_src_ip_addr;
            beat_cnt_q <= 3'd0;
            tx_data_q  <= beat_data(3'd0, 1'b1, recv_src_mac_addr, recv_src_ip_addr);
            tx_keep_q  <= beat_keep(3'd0);
            tx_last_q  <= 1'b0;
            tx_valid_q <= 1'b1;
          end else if (arp_request_req) begin
            state_q    <= REQ_TX;
            is_reply_q <= 1'b0;
            snap_mac_q <= 48'h0;
            snap_ip_q  <= dst_ip_addr;
            beat_cnt_q <= 3'd0;
            tx_data_q  <= beat_data(3'd0, 1'b0, 48'h0, dst_ip_addr);
            tx_keep_q  <= beat_keep(3'd0);
            tx_last_q  <= 1'b0;
            tx_valid_q <= 1'b1;
          end
        end
        REQ_TX, REP_TX: begin
          if (tx.tx_ready) begin
            if (tx_last_q) begin
              state_q    <= GAP;
              beat_cnt_q <= 3'd0;
              tx_valid_q <= 1'b0;
              tx_last_q  <= 1'b0;
              tx_keep_q  <= 8'h00;
              tx_data_q  <= 64'h0;
              req_ack_q  <= (state_q == REQ_TX);
              rep_ack_q  <= (state_q == REP_TX);
            end else begin
              beat_cnt_q <= beat_cnt_d;
              tx_data_q  <= beat_data(beat_cnt_d, is_reply_q, snap_mac_q, snap_ip_q);
              tx_keep_q  <= beat_keep(beat_cnt_d);
              tx_last_q  <= (beat_cnt_d == LAST_BEAT);
            end
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx.tx_data      = tx_data_q;
  assign tx.tx_keep      = tx_keep_q;
  assign tx.tx_valid     = tx_valid_q;
  assign tx.tx_last      = tx_last_q;
  assign arp_request_ack = req_ack_q;
  assign arp_reply_ack   = rep_ack_q;

endmodule

// File: tb/tb_us_arp_tx.sv
// Directed bench for us_arp_tx: request, reply, priority, stall, mid-frame reset
// and input-change-after-snapshot cases against hand-computed frame beats.
module tb_us_arp_tx;

`ifdef ARP_TX_PAD_EN
  localparam int         NB    = 8;
  localparam logic [7:0] LASTK = 8'hF0;
`else
  localparam int         NB    = 6;
  localparam logic [7:0] LASTK = 8'hC0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        arp_request_req;
  logic        arp_request_ack;
  logic [31:0] dst_ip_addr;
  logic        arp_reply_req;
  logic        arp_reply_ack;
  logic [47:0] recv_src_mac_addr;
  logic [31:0] recv_src_ip_addr;

  us_arp_tx_if txif ();

  us_arp_tx dut (
    .clk               (clk),
    .rstn              (rstn),
    .arp_request_req   (arp_request_req),
    .arp_request_ack   (arp_request_ack),
    .dst_ip_addr       (dst_ip_addr),
    .arp_reply_req     (arp_reply_req),
    .arp_reply_ack     (arp_reply_ack),
    .recv_src_mac_addr (recv_src_mac_addr),
    .recv_src_ip_addr  (recv_src_ip_addr),
    .tx                (txif.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp_req [8];
  logic [63:0] exp_rep [8];
  logic [63:0] cap_data [8];
  logic [7:0]  cap_keep [8];
  logic        cap_last [8];
  int          ncap;
  int          stall_bad;
  int          ack_early;
  bit          cap_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge where the first beat is presented; returns at the
  // negedge following acceptance of the last beat (or after the cycle budget).
  task automatic capture(input bit stall, input int chg_beat);
    int cyc;
    bit ph;
    bit held;
    logic [63:0] hd;
    logic [7:0]  hk;
    logic        hl;
    cyc = 0; ph = 1'b0; held = 1'b0; hd = '0; hk = '0; hl = 1'b0;
    ncap = 0; stall_bad = 0; ack_early = 0; cap_done = 1'b0;
    while (!cap_done && cyc < 200) begin
      if (held && txif.tx_valid &&
          (txif.tx_data !== hd || txif.tx_keep !== hk || txif.tx_last !== hl))
        stall_bad++;
      if (arp_request_ack || arp_reply_ack) ack_early++;
      if (ncap == chg_beat) dst_ip_addr = 32'hDEAD_BEEF;
      txif.tx_ready = stall ? ph : 1'b1;
      ph = ~ph;
      if (txif.tx_valid && txif.tx_ready) begin
        if (ncap < 8) begin
          cap_data[ncap] = txif.tx_data;
          cap_keep[ncap] = txif.tx_keep;
          cap_last[ncap] = txif.tx_last;
        end
        ncap++;
        held = 1'b0;
        if (txif.tx_last) cap_done = 1'b1;
      end else if (txif.tx_valid) begin
        held = 1'b1;
        hd = txif.tx_data; hk = txif.tx_keep; hl = txif.tx_last;
      end
      @(negedge clk);
      cyc++;
    end
    txif.tx_ready = 1'b1;
    chk("frame_done", {63'd0, cap_done}, 64'd1);
    chk("stall_hold", 64'(stall_bad), 64'd0);
    chk("ack_early", 64'(ack_early), 64'd0);
  endtask

  task automatic compare_frame(input string name, input bit rep);
    chk({name, "_nbeats"}, 64'(ncap), 64'(NB));
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("%s_data%0d", name, i), cap_data[i], rep ? exp_rep[i] : exp_req[i]);
      chk($sformatf("%s_keep%0d", name, i), {56'd0, cap_keep[i]},
          {56'd0, (i == NB - 1) ? LASTK : 8'hFF});
      chk($sformatf("%s_last%0d", name, i), {63'd0, cap_last[i]}, {63'd0, i == NB - 1});
    end
  endtask

  // At the GAP negedge: one ack of the right kind, then the requester drops req.
  task automatic check_end(input string name, input bit rep);
    chk({name, "_req_ack"}, {63'd0, arp_request_ack}, {63'd0, !rep});
    chk({name, "_rep_ack"}, {63'd0, arp_reply_ack}, {63'd0, rep});
    chk({name, "_gap_valid"}, {63'd0, txif.tx_valid}, 64'd0);
    if (rep) arp_reply_req = 1'b0;
    else     arp_request_req = 1'b0;
    @(negedge clk);
    chk({name, "_ack_pulse"}, {62'd0, arp_request_ack, arp_reply_ack}, 64'd0);
    chk({name, "_idle_valid"}, {63'd0, txif.tx_valid}, 64'd0);
  endtask

  initial begin
    exp_req[0] = 64'hFFFF_FFFF_FFFF_000A;
    exp_req[1] = 64'h3501_0203_0806_0001;
    exp_req[2] = 64'h0800_0604_0001_000A;
    exp_req[3] = 64'h3501_0203_C0A8_0101;
    exp_req[4] = 64'h0000_0000_0000_C0A8;
    exp_req[5] = 64'h0102_0000_0000_0000;
    exp_req[6] = 64'h0;
    exp_req[7] = 64'h0;
    exp_rep[0] = 64'h1122_3344_5566_000A;
    exp_rep[1] = 64'h3501_0203_0806_0001;
    exp_rep[2] = 64'h0800_0604_0002_000A;
    exp_rep[3] = 64'h3501_0203_C0A8_0101;
    exp_rep[4] = 64'h1122_3344_5566_C0A8;
    exp_rep[5] = 64'h0164_0000_0000_0000;
    exp_rep[6] = 64'h0;
    exp_rep[7] = 64'h0;

    rstn = 1'b0;
    arp_request_req = 1'b0;
    arp_reply_req = 1'b0;
    dst_ip_addr = 32'h0;
    recv_src_mac_addr = 48'h0;
    recv_src_ip_addr = 32'h0;
    txif.tx_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", {63'd0, txif.tx_valid}, 64'd0);
    chk("rst_last", {63'd0, txif.tx_last}, 64'd0);
    chk("rst_keep", {56'd0, txif.tx_keep}, 64'd0);
    chk("rst_data", txif.tx_data, 64'd0);
    chk("rst_acks", {62'd0, arp_request_ack, arp_reply_ack}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_valid", {63'd0, txif.tx_valid}, 64'd0);

    // Plain request frame
    dst_ip_addr = 32'hC0A8_0102;
    arp_request_req = 1'b1;
    @(negedge clk);
    chk("req_start_valid", {63'd0, txif.tx_valid}, 64'd1);
    chk("req_start_data", txif.tx_data, exp_req[0]);
    capture(1'b0, 99);
    check_end("req", 1'b0);
    compare_frame("req", 1'b0);

    // Reply frame
    recv_src_mac_addr = 48'h1122_3344_5566;
    recv_src_ip_addr = 32'hC0A8_0164;
    arp_reply_req = 1'b1;
    @(negedge clk);
    capture(1'b0, 99);
    check_end("rep", 1'b1);
    compare_frame("rep", 1'b1);

    // Simultaneous requests: reply first, GAP, IDLE, then request
    dst_ip_addr = 32'hC0A8_0102;
    arp_request_req = 1'b1;
    arp_reply_req = 1'b1;
    @(negedge clk);
    capture(1'b0, 99);
    check_end("both_rep", 1'b1);
    compare_frame("both_rep", 1'b1);
    @(negedge clk);
    chk("both_req_start", {63'd0, txif.tx_valid}, 64'd1);
    capture(1'b0, 99);
    check_end("both_req", 1'b0);
    compare_frame("both_req", 1'b0);

    // Stalled request frame: tx_ready toggles every cycle
    dst_ip_addr = 32'hC0A8_0102;
    arp_request_req = 1'b1;
    @(negedge clk);
    capture(1'b1, 99);
    check_end("stall", 1'b0);
    compare_frame("stall", 1'b0);

    // dst_ip_addr changed at beat 2 must not reach the TPA field
    dst_ip_addr = 32'hC0A8_0102;
    arp_request_req = 1'b1;
    @(negedge clk);
    capture(1'b0, 2);
    check_end("ipchg", 1'b0);
    compare_frame("ipchg", 1'b0);

    // Reset at beat 3 aborts the frame; restart after release from beat 0
    dst_ip_addr = 32'hC0A8_0102;
    arp_request_req = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("abort_beat3", txif.tx_data, exp_req[3]);
    rstn = 1'b0;
    #1;
    chk("abort_valid", {63'd0, txif.tx_valid}, 64'd0);
    chk("abort_data", txif.tx_data, 64'd0);
    chk("abort_acks", {62'd0, arp_request_ack, arp_reply_ack}, 64'd0);
    repeat (2) @(negedge clk);
    chk("abort_hold_acks", {62'd0, arp_request_ack, arp_reply_ack}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("restart_valid", {63'd0, txif.tx_valid}, 64'd1);
    chk("restart_data0", txif.tx_data, exp_req[0]);
    capture(1'b0, 99);
    check_end("restart", 1'b0);
    compare_frame("restart", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/us_arp_tx.md
US_ARP_TX -- requirements
Module: us_arp_tx

Interface
REQ-001 Parameter LOCAL_MAC, 48'h00_0A_35_01_02_03, own MAC address.
REQ-002 Parameter LOCAL_IP, 32'hC0A8_0101, own IPv4 address.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rstn  in  1  reset, asynchronous assert, active-low.
REQ-005 arp_request_req  in  1  level; request to send an ARP who-has for dst_ip_addr.
REQ-006 arp_request_ack  out  1  one-cycle pulse; request frame fully sent.
REQ-007 dst_ip_addr  in  32  IP to resolve; sampled at request-frame start.
REQ-008 arp_reply_req  in  1  level; request to answer a received ARP request.
REQ-009 arp_reply_ack  out  1  one-cycle pulse; reply frame fully sent.
REQ-010 recv_src_mac_addr  in  48  requester MAC; sampled at reply-frame start.
REQ-011 recv_src_ip_addr  in  32  requester IP; sampled at reply-frame start.
REQ-012 tx_data  out  64  frame beat; first wire byte in [63:56].
REQ-013 tx_keep  out  8  byte enables; bit 7 maps to [63:56].
REQ-014 tx_valid  out  1  beat valid.
REQ-015 tx_last  out  1  final beat of frame.
REQ-016 tx_ready  in  1  sink accepts beat when tx_valid and tx_ready are both high.

Function
REQ-017 The block SHALL use states IDLE, REQ_TX, REP_TX and GAP.
REQ-018 IDLE: arp_reply_req high -> REP_TX; otherwise arp_request_req high -> REQ_TX; reply wins on simultaneous requests.
REQ-019 On leaving IDLE, the block SHALL snapshot the target IP/MAC into internal registers; input changes mid-frame SHALL NOT alter the frame.
REQ-020 The first beat SHALL be valid the cycle after leaving IDLE (one-cycle start latency).
REQ-021 A 3-bit beat counter SHALL advance only on accepted beats; tx_data, tx_keep and tx_last SHALL hold while tx_valid is high and tx_ready is low.
REQ-022 Frame bytes in order: dst MAC (request FF:FF:FF:FF:FF:FF, reply = snapshot MAC), LOCAL_MAC, 0x0806, 0x0001, 0x0800, 0x06, 0x04, oper (request 0x0001, reply 0x0002), LOCAL_MAC, LOCAL_IP, THA (request 00..00, reply = snapshot MAC), TPA (snapshot IP); 42 bytes total.
REQ-023 tx_keep SHALL be 8'hFF on every beat except the last.
REQ-024 On acceptance of the last beat, the block SHALL pulse the matching ack for exactly one cycle and enter GAP.
REQ-025 GAP SHALL last one cycle with tx_valid low, then return to IDLE.
REQ-026 A req still high on return to IDLE SHALL start a new frame; the requester drops req on ack.
REQ-027 Only one of arp_request_ack and arp_reply_ack SHALL be high in any cycle.

Reset
REQ-028 While rstn is low: state IDLE, beat counter 0, tx_valid 0, tx_last 0, tx_keep 8'h00, tx_data 0, both acks 0, snapshots 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately without an ack; the first frame after release SHALL start at beat 0.

Configuration
REQ-030 Macro ARP_TX_PAD_EN defined: the frame SHALL be zero-padded to 60 bytes, giving 8 beats with the last tx_keep 8'hF0.
REQ-031 Macro ARP_TX_PAD_EN undefined: the frame SHALL be 42 bytes, giving 6 beats with the last tx_keep 8'hC0.

Verification
REQ-032 arp_request_req=1, dst_ip_addr=C0A80102, tx_ready=1 -> beat0 FFFFFFFFFFFF000A, beat1 35010203 0806 0001; TPA C0A80102 at bytes 38-41; one-cycle arp_request_ack on the last beat.
REQ-033 arp_reply_req=1, recv_src_mac_addr=112233445566, recv_src_ip_addr=C0A80164 -> dst MAC 112233445566, oper 0002, THA 112233445566, TPA C0A80164; one-cycle arp_reply_ack.
REQ-034 Both reqs rise in the same cycle -> reply frame, GAP cycle, then request frame.
REQ-035 tx_ready toggled 1/0 each cycle -> beats held stable while stalled; frame identical to the unstalled one; beat count 8 (padded) or 6 (unpadded).
REQ-036 rstn low at beat 3 -> tx_valid 0 at once, no ack; after release with req high, a full frame starts at beat 0.
REQ-037 dst_ip_addr changed at beat 2 -> TPA still carries the IP sampled at frame start.
